tiny_mips_cpu: RTL and testbench
================================

Name: tiny_mips_cpu

Overview:
- Multicycle 16-bit von Neumann CPU core with eight 16-bit general registers (RF[0..7]), a SIZE-bit program counter (PC) and a small state register (st).
- Instructions and data share one external synchronous single-port RAM. The RAM has 1-cycle read latency and a write-on-clock-edge when wrEn is high.
- The core sits directly on that RAM.
- A bench must be able to see RF, PC and st by hierarchical reference.

Parameters:
- SIZE, 8, RAM address width. Instruction memory and data memory are both 2^SIZE words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- data_fromRAM  input  16  RAM read data; valid the cycle after its address was presented.
- wrEn  output  1  RAM write enable.
- addr_toRAM  output  SIZE  RAM address.
- data_toRAM  output  16  RAM write data.

Behaviour:
Instruction fields:
- op = [15:12], rA = [11:9], rB = [8:6], rC = [5:3].
- imm6 = [5:0], sign-extended.
- imm9 = [8:0], zero-extended.
- imm12 = [11:0], sign-extended.

Opcodes:
- 0 ADD: rA = rB + rC.
- 1 ADDi: rA = rB + imm6.
- 2 SUB: rA = rB - rC.
- 3 AND: rA = rB & rC.
- 4 OR: rA = rB | rC.
- 5 LD: rA = mem[rB + imm6].
- 6 ST: mem[rB + imm6] = rA.
- 7 CPi: rA = imm9.
- 8 BEQ: if rA == rB then PC = PC + imm6.
- 9 BLT: if signed rA < signed rB then PC = PC + imm6.
- A JMP: PC = PC + imm12.
- B-E: NOP.
- F: HALT (see Optional Feature).

Arithmetic and address rules:
- Register arithmetic is 16-bit modulo; there are no flags.
- All eight registers are writable.
- Branch offsets are relative to the branch instruction's own address, e.g. BLT at 5 with imm -2 goes to 3.
- Not-taken branches and all other non-jump instructions set PC = PC + 1.
- PC and effective addresses are truncated to SIZE bits and wrap modulo 2^SIZE.

States (st encoding):
- FETCH = 0:
  - addr_toRAM = PC, wrEn = 0.
  - Next state is EXEC.
- EXEC = 1:
  - data_fromRAM is the instruction; it is decoded combinationally with no IR latch.
  - ALU ops, CPi, branches and JMP write RF and PC at the clock edge, then go to FETCH.
  - LD: drives addr_toRAM = effective address and goes to LDWB. PC is incremented at the same edge.
  - ST: drives addr_toRAM = effective address, data_toRAM = RF[rA], wrEn = 1. PC is incremented, then go to FETCH.
- LDWB = 2:
  - RF[rA] = data_fromRAM, then go to FETCH.
- HALT = 3:
  - Holds all state; wrEn = 0; addr_toRAM = PC.

Timing:
- Outside the cases above, addr_toRAM = PC and data_toRAM = RF[rA] of the current decode (don't-care).
- Cycle counts: ALU/branch/ST take 2 cycles; LD takes 3 cycles.
- wrEn is never high outside EXEC with op = 6.

Reset (rst low, asynchronous):
- PC = 0, st = FETCH, all RF = 0, wrEn = 0.
- Reset mid-instruction aborts it: no partial RF or RAM write.
- The first fetch of address 0 occurs in the first cycle after rst is released.

Optional Feature:
- Macro: TINYMIPS_HALT_EN.
- Defined: opcode F in EXEC enters HALT; PC is not incremented. Only reset leaves HALT.
- Undefined: opcode F is a NOP (PC + 1); the HALT state is unreachable.

Test Plan:
- Sum loop:
  - Program: mem[0] = 0x7201 (CPi R1 1), mem[1] = 0x7400 (CPi R2 0), mem[2] = 0x7606 (CPi R3 6), mem[3] = 0x0488 (ADD R2 R2 R1), mem[4] = 0x1241 (ADDi R1 R1 1), mem[5] = 0x92FE (BLT R1 R3 -2).
  - Required: within 40 cycles of rst release, RF[2] = 15, RF[1] = 6, RF[3] = 6.
- LD/ST:
  - Stimulus: CPi R1 100; CPi R4 0x1AB; ST R4 -> [R1+2]; LD R5 <- [R1+2].
  - Required: mem[102] = 0x01AB; RF[5] = 0x01AB; wrEn high exactly one cycle.
- Signed compare and BEQ:
  - Stimulus: R1 = 0xFFFF, R2 = 1; BLT R1 R2 taken; BLT R2 R1 not taken; BEQ R1 R1 +3 taken.
  - Required: PC = branch address + 3 for BEQ.
- Reset mid-operation:
  - Stimulus: assert rst during EXEC of a ST.
  - Required: RAM unchanged; PC = 0, st = 0, RF all 0 immediately (asynchronous).
- Wrap and immediates:
  - Stimulus: CPi R1 511, then ADDi R1 R1 -1; JMP at address 255 with imm12 = +1.
  - Required: RF[1] = 0x01FF then 0x01FE; PC wraps to 0.
- HALT (TINYMIPS_HALT_EN):
  - Stimulus: 0xF000 at address 2.
  - Required: st = 3, PC = 2 indefinitely.
  - Without the macro: PC advances to 3.

Source files
------------

// File: rtl/tiny_mips_cpu.sv
// tiny_mips_cpu: multicycle 16-bit von Neumann core sitting directly on a 1-cycle-latency single-port RAM.
// Optional feature macro: TINYMIPS_HALT_EN (opcode F halts the core until reset).
module tiny_mips_cpu #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     data_fromRAM,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [15:0]     data_toRAM
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    LDWB  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          st;
  state_t          stNext_s;
  logic [SIZE-1:0] PC;
  logic [SIZE-1:0] pcNext_s;
  logic [15:0]     RF [8];

  logic [2:0]      ldDst_r;
  logic [2:0]      ldDstNext_s;
  logic            rfWe_s;
  logic [2:0]      rfWaddr_s;
  logic [15:0]     rfWdata_s;

  logic [3:0]      op_s;
  logic [2:0]      rA_s;
  logic [2:0]      rB_s;
  logic [2:0]      rC_s;
  logic [15:0]     imm6Ext_s;
  logic [SIZE-1:0] off6_s;
  logic [SIZE-1:0] off12_s;
  logic [SIZE-1:0] eaAddr_s;
  logic [SIZE-1:0] pcOne_s;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  // Combinational decode of the word on the RAM read port; there is no instruction latch.
  always_comb begin
    op_s      = data_fromRAM[15:12];
    rA_s      = data_fromRAM[11:9];
    rB_s      = data_fromRAM[8:6];
    rC_s      = data_fromRAM[5:3];
    imm6Ext_s = sext6(data_fromRAM[5:0]);
    off6_s    = SIZE'(imm6Ext_s);
    off12_s   = SIZE'(sext12(data_fromRAM[11:0]));
    eaAddr_s  = RF[rB_s][SIZE-1:0] + off6_s;
    pcOne_s   = {{(SIZE-1){1'b0}}, 1'b1};
  end

  // Next-state, next-PC, register-file write and RAM port control.
  always_comb begin
    stNext_s    = st;
    pcNext_s    = PC;
    ldDstNext_s = ldDst_r;
    rfWe_s      = 1'b0;
    rfWaddr_s   = rA_s;
    rfWdata_s   = 16'h0000;
    wrEn        = 1'b0;
    addr_toRAM  = PC;
    data_toRAM  = RF[rA_s];
    case (st)
      FETCH: begin
        stNext_s = EXEC;
      end
      EXEC: begin
        stNext_s = FETCH;
        pcNext_s = PC + pcOne_s;
        case (op_s)
          4'h0: begin
            rfWe_s    = 1'b1;
            rfWdata_s = RF[rB_s] + RF[rC_s];
          end
          4'h1: begin
            rfWe_s    = 1'b1;
            rfWdata_s = RF[rB_s] + imm6Ext_s;
          end
          4'h2: begin
            rfWe_s    = 1'b1;
            rfWdata_s = RF[rB_s] - RF[rC_s];
          end
          4'h3: begin
            rfWe_s    = 1'b1;
            rfWdata_s = RF[rB_s] & RF[rC_s];
          end
          4'h4: begin
            rfWe_s    = 1'b1;
            rfWdata_s = RF[rB_s] | RF[rC_s];
          end
          4'h5: begin
            // The destination index must outlive the instruction word on the read port.
            addr_toRAM  = eaAddr_s;
            ldDstNext_s = rA_s;
            stNext_s    = LDWB;
          end
          4'h6: begin
            addr_toRAM = eaAddr_s;
            wrEn       = 1'b1;
          end
          4'h7: begin
            rfWe_s    = 1'b1;
            rfWdata_s = {7'd0, data_fromRAM[8:0]};
          end
          4'h8: begin
            if (RF[rA_s] == RF[rB_s]) begin
              pcNext_s = PC + off6_s;
            end else begin
              pcNext_s = PC + pcOne_s;
            end
          end
          4'h9: begin
            if ($signed(RF[rA_s]) < $signed(RF[rB_s])) begin
              pcNext_s = PC + off6_s;
            end else begin
              pcNext_s = PC + pcOne_s;
            end
          end
          4'hA: begin
            pcNext_s = PC + off12_s;
          end
`ifdef TINYMIPS_HALT_EN
          4'hF: begin
            pcNext_s = PC;
            stNext_s = HALT;
          end
`endif
          default: begin
            pcNext_s = PC + pcOne_s;
          end
        endcase
      end
      LDWB: begin
        rfWe_s    = 1'b1;
        rfWaddr_s = ldDst_r;
        rfWdata_s = data_fromRAM;
        stNext_s  = FETCH;
      end
      HALT: begin
        stNext_s = HALT;
      end
      default: begin
        stNext_s = FETCH;
      end
    endcase
  end

  // Architectural state; reset clears everything so an interrupted instruction leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= FETCH;
      PC      <= '0;
      ldDst_r <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        RF[i] <= 16'h0000;
      end
    end else begin
      st      <= stNext_s;
      PC      <= pcNext_s;
      ldDst_r <= ldDstNext_s;
      if (rfWe_s) begin
        RF[rfWaddr_s] <= rfWdata_s;
      end
    end
  end

endmodule

// File: tb/tb_tiny_mips_cpu.sv
// Bench for tiny_mips_cpu: directed programs plus random programs checked against an ISA-level model.
// Honours TINYMIPS_HALT_EN the same way as the design.
module tb_tiny_mips_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_fromRAM = 16'h0000;
  logic        wrEn;
  logic [7:0]  addr_toRAM;
  logic [15:0] data_toRAM;

  logic [15:0] mem  [256];
  logic [15:0] img  [256];
  logic        loadReq;
  int          wrCount = 0;

  logic [15:0] mRf  [8];
  logic [15:0] mMem [256];
  int          mPc;

  int checks = 0;
  int errors = 0;

  tiny_mips_cpu #(.SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_fromRAM (data_fromRAM),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, 1-cycle read latency; loadReq copies a whole image in one cycle.
  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (wrEn) begin
      mem[addr_toRAM] <= data_toRAM;
      wrCount <= wrCount + 1;
    end
    data_fromRAM <= mem[addr_toRAM];
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
  endtask

  // Holds reset, loads img into the RAM and the model, releases reset on a falling edge.
  task automatic startProgram();
    rst = 1'b0;
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mMem[i] = img[i];
    for (int i = 0; i < 8; i++) mRf[i] = 16'h0000;
    mPc = 0;
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instruction-set model: executes one instruction, reports its cycle cost and any store address.
  task automatic modelStep(output int cyc, output int stAddr);
    logic [15:0] ins;
    int op, ra, rb, rc, imm6, imm12, ea, nextPc;
    ins = mMem[mPc];
    op = int'(ins[15:12]);
    ra = int'(ins[11:9]);
    rb = int'(ins[8:6]);
    rc = int'(ins[5:3]);
    imm6 = int'(ins[5:0]);
    if (imm6 >= 32) imm6 -= 64;
    imm12 = int'(ins[11:0]);
    if (imm12 >= 2048) imm12 -= 4096;
    ea = (int'(mRf[rb]) + imm6) & 255;
    nextPc = (mPc + 1) & 255;
    cyc = 2;
    stAddr = -1;
    case (op)
      0: mRf[ra] = mRf[rb] + mRf[rc];
      1: mRf[ra] = 16'(int'(mRf[rb]) + imm6);
      2: mRf[ra] = mRf[rb] - mRf[rc];
      3: mRf[ra] = mRf[rb] & mRf[rc];
      4: mRf[ra] = mRf[rb] | mRf[rc];
      5: begin mRf[ra] = mMem[ea]; cyc = 3; end
      6: begin mMem[ea] = mRf[ra]; stAddr = ea; end
      7: mRf[ra] = {7'd0, ins[8:0]};
      8: if (mRf[ra] == mRf[rb]) nextPc = (mPc + imm6) & 255;
      9: if ($signed(mRf[ra]) < $signed(mRf[rb])) nextPc = (mPc + imm6) & 255;
      10: nextPc = (mPc + imm12) & 255;
      default: ;
    endcase
    mPc = nextPc;
  endtask

  initial begin
    int cyc, stA, base, stores;
    rst = 1'b1;
    loadReq = 1'b0;
    clearImg();
    #2;
    rst = 1'b0;
    #1;
    check16("rst_pc", {8'h00, dut.PC}, 16'h0000);
    check16("rst_st", {14'd0, dut.st}, 16'h0000);
    check16("rst_wren", {15'd0, wrEn}, 16'h0000);
    for (int r = 0; r < 8; r++) check16("rst_rf", dut.RF[r], 16'h0000);
    @(negedge clk);

    // Sum loop 1..5
    clearImg();
    img[0] = 16'h7201; img[1] = 16'h7400; img[2] = 16'h7606;
    img[3] = 16'h0488; img[4] = 16'h1241; img[5] = 16'h92FE;
    startProgram();
    step(40);
    check16("sum_r2", dut.RF[2], 16'd15);
    check16("sum_r1", dut.RF[1], 16'd6);
    check16("sum_r3", dut.RF[3], 16'd6);

    // Store then load through the same effective address
    clearImg();
    img[0] = 16'h7264; img[1] = 16'h79AB; img[2] = 16'h6842; img[3] = 16'h5A42;
    startProgram();
    base = wrCount;
    step(9);
    check16("ldst_mem", mem[102], 16'h01AB);
    check16("ldst_r5", dut.RF[5], 16'h01AB);
    check16("ldst_wrcnt", 16'(wrCount - base), 16'd1);
    check16("ldst_pc", {8'h00, dut.PC}, 16'd4);

    // Signed compare and BEQ
    clearImg();
    img[0] = 16'h123F; img[1] = 16'h7401; img[2] = 16'h9282;
    img[3] = 16'h7E55; img[4] = 16'h9443; img[5] = 16'h8243;
    startProgram();
    step(2); check16("sgn_r1", dut.RF[1], 16'hFFFF);
    step(2); check16("sgn_r2", dut.RF[2], 16'h0001);
    step(2); check16("blt_taken_pc", {8'h00, dut.PC}, 16'd4);
    step(2); check16("blt_not_pc", {8'h00, dut.PC}, 16'd5);
    step(2); check16("beq_pc", {8'h00, dut.PC}, 16'd8);
    check16("skip_r7", dut.RF[7], 16'h0000);

    // Reset asserted during EXEC of a store
    clearImg();
    img[0] = 16'h79AB; img[1] = 16'h680A; img[10] = 16'h1234;
    startProgram();
    base = wrCount;
    step(3);
    check16("mid_st_exec", {14'd0, dut.st}, 16'd1);
    check16("mid_st_wren", {15'd0, wrEn}, 16'd1);
    rst = 1'b0;
    #1;
    check16("mid_pc", {8'h00, dut.PC}, 16'h0000);
    check16("mid_st", {14'd0, dut.st}, 16'h0000);
    check16("mid_wren", {15'd0, wrEn}, 16'h0000);
    for (int r = 0; r < 8; r++) check16("mid_rf", dut.RF[r], 16'h0000);
    step(2);
    check16("mid_mem", mem[10], 16'h1234);
    check16("mid_wrcnt", 16'(wrCount - base), 16'd0);

    // Immediates and PC wrap
    clearImg();
    img[0] = 16'h73FF; img[1] = 16'h127F; img[2] = 16'hA0FD; img[255] = 16'hA001;
    startProgram();
    step(2); check16("cpi_511", dut.RF[1], 16'h01FF);
    step(2); check16("addi_m1", dut.RF[1], 16'h01FE);
    step(2); check16("jmp_255", {8'h00, dut.PC}, 16'd255);
    step(2); check16("pc_wrap", {8'h00, dut.PC}, 16'd0);

    // Opcode F
    clearImg();
    img[0] = 16'hB000; img[1] = 16'hB000; img[2] = 16'hF000;
    startProgram();
    step(6);
`ifdef TINYMIPS_HALT_EN
    check16("halt_st", {14'd0, dut.st}, 16'd3);
    check16("halt_pc", {8'h00, dut.PC}, 16'd2);
    step(10);
    check16("halt_st_hold", {14'd0, dut.st}, 16'd3);
    check16("halt_pc_hold", {8'h00, dut.PC}, 16'd2);
    check16("halt_wren", {15'd0, wrEn}, 16'd0);
`else
    check16("nohalt_pc", {8'h00, dut.PC}, 16'd3);
    check16("nohalt_st", {14'd0, dut.st}, 16'd0);
`endif

    // Random programs against the model
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) img[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      startProgram();
      base = wrCount;
      stores = 0;
      for (int k = 0; k < 50; k++) begin
        modelStep(cyc, stA);
        step(cyc);
        check16("rnd_pc", {8'h00, dut.PC}, 16'(mPc));
        for (int r = 0; r < 8; r++) check16("rnd_rf", dut.RF[r], mRf[r]);
        if (stA >= 0) begin
          stores++;
          check16("rnd_mem", mem[stA], mMem[stA]);
        end
      end
      check16("rnd_wrcnt", 16'(wrCount - base), 16'(stores));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
